// File: rtl/fifo_pkg.sv
// fifo_pkg
//  Shared types and helpers for the single-clock and dual-clock FIFO family.
//  fifo_mode_e      : read-side behaviour (registered read vs first-word-fall-through)
//  fifo_level_bits  : width of a level counter able to hold 0..size inclusive
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int fifo_level_bits(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//  SIZE x BITS flop storage, one synchronous write port and one
//  combinational read port. Contents are deliberately not reset.
//  clk    : write clock
//  we     : write strobe
//  waddr  : write entry index (0..SIZE-1)
//  wdata  : write data
//  raddr  : read entry index (0..SIZE-1)
//  rdata  : mem[raddr], combinational
module fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [SIZE-1:0][BITS-1:0] mem;

  // One enable per entry keeps the decode explicit for non power-of-two SIZE.
  for (genvar i = 0; i < SIZE; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(i))) mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
//  Single-clock FIFO of any depth >= 2 with standard or FWFT read mode,
//  programmable almost-full/almost-empty, fill level, sticky error flags
//  and synchronous flush.
//  clk, rst_n            : clock, synchronous active-low reset
//  p_clear               : synchronous flush of pointers, level and sticky flags
//  p_write_en/_data      : write request and data
//  p_write_full          : level == SIZE
//  p_write_almost_full   : level >= AFULL_LEVEL
//  p_read_en             : read request (FWFT: pop of the shown head)
//  p_read_data           : read data
//  p_read_empty          : level == 0
//  p_read_almost_empty   : level <= AEMPTY_LEVEL
//  p_level               : current entry count
//  p_overflow/underflow  : sticky, write while full / read while empty
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int SIZE         = 16,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             p_clear,
  input  logic                             p_write_en,
  input  logic [BITS-1:0]                  p_write_data,
  output logic                             p_write_full,
  output logic                             p_write_almost_full,
  input  logic                             p_read_en,
  output logic [BITS-1:0]                  p_read_data,
  output logic                             p_read_empty,
  output logic                             p_read_almost_empty,
  output logic [fifo_level_bits(SIZE)-1:0] p_level,
  output logic                             p_overflow,
  output logic                             p_underflow
);

  localparam int LW = fifo_level_bits(SIZE);
  localparam int AW = $clog2(SIZE);

  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_MAX  = LW'(SIZE);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(SIZE - 1);
  localparam bit            IS_FWFT  = (FWFT == int'(FIFO_FWFT));

  if (SIZE < 2) begin : g_bad_size
    $fatal(1, "sync_fifo: SIZE must be >= 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > SIZE) begin : g_bad_afull
    $fatal(1, "sync_fifo: AFULL_LEVEL must be in 1..SIZE");
  end
  if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > SIZE - 1) begin : g_bad_aempty
    $fatal(1, "sync_fifo: AEMPTY_LEVEL must be in 0..SIZE-1");
  end
  if (FWFT < 0 || FWFT > 1) begin : g_bad_fwft
    $fatal(1, "sync_fifo: FWFT must be 0 or 1");
  end

  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic            empty_q, full_q, afull_q, aempty_q;
  logic            ovf_q, unf_q;
  logic [BITS-1:0] rd_data_q, mem_rdata;
  logic            write_ok, read_ok, mem_we;

  // Acceptance looks only at registered flags: a read does not free a slot
  // for a write in the same cycle.
  assign write_ok = p_write_en & ~full_q;
  assign read_ok  = p_read_en  & ~empty_q;
  assign mem_we   = write_ok & rst_n & ~p_clear;

  // Explicit compare-wrap so any SIZE works, not just powers of two.
  assign wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
  assign rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;

  always_comb begin
    lvl_d = lvl_q;
    if (p_clear)                  lvl_d = '0;
    else if (write_ok && !read_ok) lvl_d = lvl_q + LVL_ONE;
    else if (read_ok && !write_ok) lvl_d = lvl_q - LVL_ONE;
  end

  fifo_mem #(
    .BITS (BITS),
    .SIZE (SIZE),
    .AW   (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (p_write_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lvl_q     <= '0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      // Flags derive from next level so they move on the same edge as p_level.
      lvl_q    <= lvl_d;
      empty_q  <= (lvl_d == '0);
      full_q   <= (lvl_d == LVL_MAX);
      afull_q  <= (lvl_d >= AFULL_L);
      aempty_q <= (lvl_d <= AEMPTY_L);
      if (p_clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end else begin
        if (write_ok) wr_ptr_q <= wr_ptr_d;
        if (read_ok)  rd_ptr_q <= rd_ptr_d;
        if (p_write_en && full_q) ovf_q <= 1'b1;
        if (p_read_en && empty_q) unf_q <= 1'b1;
        if (!IS_FWFT && read_ok)  rd_data_q <= mem_rdata;
      end
    end
  end

  // FWFT shows the head combinationally; zero while empty so stale memory
  // never leaks onto the bus.
  assign p_read_data         = IS_FWFT ? (empty_q ? '0 : mem_rdata) : rd_data_q;
  assign p_write_full        = full_q;
  assign p_write_almost_full = afull_q;
  assign p_read_empty        = empty_q;
  assign p_read_almost_empty = aempty_q;
  assign p_level             = lvl_q;
  assign p_overflow          = ovf_q;
  assign p_underflow         = unf_q;

endmodule
